fetch_controller: RTL

//  Sequences the instruction-fetch datapath: owns the program counter, issues
//  req/ack reads to instruction memory, buffers one fetched instruction and

---
 rtl/fetch_controller_if.sv | 64 ++++++
 rtl/fetch_controller.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller_if
// Description : Bundle of the control, instruction-memory and decode-side
//               signals of the instruction fetch controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_controller_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
) ();
    // Fetch control from the update_pc / register-file side
    logic                   enable;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_target;

    // Instruction memory read channel
    logic                   mem_req;
    logic [ADDR_WIDTH-1:0]  mem_addr;
    logic                   mem_ack;
    logic [INSTR_WIDTH-1:0] mem_data;

    // Decode handoff
    logic                   instr_valid;
    logic [INSTR_WIDTH-1:0] instr_out;
    logic [ADDR_WIDTH-1:0]  instr_pc;
    logic                   instr_ready;

    // Next fetch address
    logic [ADDR_WIDTH-1:0]  pc;

    // Seen from the fetch controller
    modport master (
        input  enable,
        input  redirect_valid,
        input  redirect_target,
        output mem_req,
        output mem_addr,
        input  mem_ack,
        input  mem_data,
        output instr_valid,
        output instr_out,
        output instr_pc,
        input  instr_ready,
        output pc
    );

    // Seen from the surrounding pipeline and memory
    modport slave (
        output enable,
        output redirect_valid,
        output redirect_target,
        input  mem_req,
        input  mem_addr,
        output mem_ack,
        output mem_data,
        input  instr_valid,
        input  instr_out,
        input  instr_pc,
        output instr_ready,
        input  pc
    );
endinterface
`default_nettype wire

// File: rtl/fetch_controller.sv
`default_nettype none
// ============================================================================
// Module      : fetch_controller
// Description : Owns the program counter, issues req/ack reads to instruction
//               memory, buffers one fetched word and hands it to decode with a
//               valid/ready handshake. Branch redirects squash in-flight reads.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_controller #(
    parameter int                    ADDR_WIDTH  = 32,
    parameter int                    INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
    parameter int                    PC_STEP     = 4
) (
    input  wire logic          clock,
    input  wire logic          reset,
    fetch_controller_if.master bus
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(PC_STEP);

    // IDLE    : no read outstanding, nothing buffered
    // REQUEST : read outstanding whose data will be kept
    // HOLD    : one word buffered, waiting for decode
    // DRAIN   : read outstanding whose data was made stale by a redirect
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        HOLD    = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_state;

    logic [ADDR_WIDTH-1:0]  r_pc;
    logic [ADDR_WIDTH-1:0]  w_pc;
    logic                   r_mem_req;
    logic                   w_mem_req;
    logic [ADDR_WIDTH-1:0]  r_mem_addr;
    logic [ADDR_WIDTH-1:0]  w_mem_addr;
    logic                   r_instr_valid;
    logic                   w_instr_valid;
    logic [INSTR_WIDTH-1:0] r_instr_out;
    logic [INSTR_WIDTH-1:0] w_instr_out;
    logic [ADDR_WIDTH-1:0]  r_instr_pc;
    logic [ADDR_WIDTH-1:0]  w_instr_pc;
    // Set while the outstanding read belongs to a redirected-away stream
    logic                   r_squash;
    logic                   w_squash;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    // Next-state and next-output decode; redirect outranks every other event
    always_comb begin
        w_state       = r_state;
        w_pc          = r_pc;
        w_mem_req     = r_mem_req;
        w_mem_addr    = r_mem_addr;
        w_instr_valid = r_instr_valid;
        w_instr_out   = r_instr_out;
        w_instr_pc    = r_instr_pc;
        w_squash      = r_squash;

        case (r_state)
            IDLE: begin
                w_squash = 1'b0;
                if (bus.redirect_valid) begin
                    w_pc = bus.redirect_target;
                    if (bus.enable) begin
                        w_state    = REQUEST;
                        w_mem_req  = 1'b1;
                        w_mem_addr = bus.redirect_target;
                    end
                end else if (bus.enable) begin
                    w_state    = REQUEST;
                    w_mem_req  = 1'b1;
                    w_mem_addr = r_pc;
                end
            end

            REQUEST: begin
                if (bus.redirect_valid) begin
                    w_pc = bus.redirect_target;
                    if (bus.mem_ack) begin
                        // The returning word is stale; reissue straight away
                        // at the new target without dropping the request.
                        w_mem_req  = 1'b1;
                        w_mem_addr = bus.redirect_target;
                    end else begin
                        // Memory handshake cannot be aborted: wait it out.
                        w_state  = DRAIN;
                        w_squash = 1'b1;
                    end
                end else if (bus.mem_ack) begin
                    w_state       = HOLD;
                    w_mem_req     = 1'b0;
                    w_instr_valid = 1'b1;
                    w_instr_out   = bus.mem_data;
                    w_instr_pc    = r_mem_addr;
                    w_pc          = r_pc + STEP;
                end
            end

            HOLD: begin
                if (bus.redirect_valid) begin
                    // Buffered word is dropped (or was just taken by decode).
                    w_instr_valid = 1'b0;
                    w_pc          = bus.redirect_target;
                    if (bus.enable) begin
                        w_state    = REQUEST;
                        w_mem_req  = 1'b1;
                        w_mem_addr = bus.redirect_target;
                    end else begin
                        w_state = IDLE;
                    end
                end else if (bus.instr_ready) begin
                    w_instr_valid = 1'b0;
                    if (bus.enable) begin
                        w_state    = REQUEST;
                        w_mem_req  = 1'b1;
                        w_mem_addr = r_pc;
                    end else begin
                        w_state = IDLE;
                    end
                end
            end

            DRAIN: begin
                if (bus.redirect_valid) begin
                    w_pc = bus.redirect_target;
                end
                if (bus.mem_ack) begin
                    // Stale data is discarded; IDLE relaunches at pc if enabled.
                    w_state   = IDLE;
                    w_mem_req = 1'b0;
                    w_squash  = 1'b0;
                end
            end

            default: begin
                w_state   = IDLE;
                w_mem_req = 1'b0;
                w_squash  = 1'b0;
            end
        endcase
    end

    // Datapath registers; reset clears everything immediately
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_pc          <= RESET_PC;
            r_mem_req     <= 1'b0;
            r_mem_addr    <= '0;
            r_instr_valid <= 1'b0;
            r_instr_out   <= '0;
            r_instr_pc    <= '0;
            r_squash      <= 1'b0;
        end else begin
            r_pc          <= w_pc;
            r_mem_req     <= w_mem_req;
            r_mem_addr    <= w_mem_addr;
            r_instr_valid <= w_instr_valid;
            r_instr_out   <= w_instr_out;
            r_instr_pc    <= w_instr_pc;
            r_squash      <= w_squash;
        end
    end

    assign bus.pc          = r_pc;
    assign bus.mem_req     = r_mem_req;
    assign bus.mem_addr    = r_mem_addr;
    assign bus.instr_valid = r_instr_valid;
    assign bus.instr_out   = r_instr_out;
    assign bus.instr_pc    = r_instr_pc;

endmodule
`default_nettype wire
